// File: rtl/display_scan_n.sv
// Multiplexed seven-segment scanner for N_DIGITS hex digits.
// Double-buffered display registers (pending/active) swap on frame
// boundaries. Also provides leading-zero blanking and per-digit blinking.
// All outputs are registered, one cycle behind the scan index.
module display_scan_n #(
  parameter int N_DIGITS       = 8,
  parameter int BLINK_DIV      = 50,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk_200Hz,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_blank,
  output logic [7:0]            sm_duan,
  output logic [N_DIGITS-1:0]   sm_wei,
  output logic                  frame_done,
  output logic                  load_pending
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]          BLINK_LAST = 8'(BLINK_DIV - 1);
  localparam logic [7:0]          SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] WEI_OFF    = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [IDX_W-1:0]    idx_reg;
  logic [4*N_DIGITS-1:0] active_data_reg, pending_data_reg;
  logic [N_DIGITS-1:0] active_dots_reg, pending_dots_reg;
  logic [N_DIGITS-1:0] active_blink_reg, pending_blink_reg;
  logic                load_pending_reg;
  logic [7:0]          blink_cnt_reg;
  logic                blink_phase_reg;
  logic                frame_done_reg;
  logic [7:0]          sm_duan_reg;
  logic [N_DIGITS-1:0] sm_wei_reg;

  logic                boundary;
  logic [N_DIGITS-1:0] wei_sel;
  logic [7:0]          seg_digit [N_DIGITS];

  // Hex nibble to active-high a..g pattern (bit0 = a).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  // The last digit of an enabled scan closes the frame.
  assign boundary = EN && (idx_reg == IDX_LAST);
  assign wei_sel  = N_DIGITS'(1) << idx_reg;

  // Per-digit active-high segment byte including blanking and blink darkening.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    logic       upper_zero;
    logic       blank;
    logic       dark;
    assign nib        = active_data_reg[gi*4 +: 4];
    assign upper_zero = (active_data_reg[4*N_DIGITS-1:gi*4] == '0);
    assign blank      = lz_blank && (gi != 0) && upper_zero;
    assign dark       = blink_phase_reg && active_blink_reg[gi];
    assign seg_digit[gi] = dark ? 8'h00 : {active_dots_reg[gi], (blank ? 7'h00 : hex_to_seg(nib))};
  end

  // Scan index, registered digit select / segment outputs and frame pulse.
  always_ff @(posedge clk_200Hz) begin
    if (rst) begin
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
      sm_wei_reg     <= WEI_OFF;
      sm_duan_reg    <= SEG_OFF;
    end else begin
      frame_done_reg <= boundary;
      if (EN) begin
        idx_reg     <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        sm_wei_reg  <= (AN_ACTIVE_LOW != 0) ? ~wei_sel : wei_sel;
        sm_duan_reg <= (SEG_ACTIVE_LOW != 0) ? ~seg_digit[idx_reg] : seg_digit[idx_reg];
      end else begin
        sm_wei_reg  <= WEI_OFF;
        sm_duan_reg <= SEG_OFF;
      end
    end
  end

  // Double buffer: direct write when idle or on a boundary, else stage in pending.
  always_ff @(posedge clk_200Hz) begin
    if (rst) begin
      active_data_reg   <= '0;
      active_dots_reg   <= '0;
      active_blink_reg  <= '0;
      pending_data_reg  <= '0;
      pending_dots_reg  <= '0;
      pending_blink_reg <= '0;
      load_pending_reg  <= 1'b0;
    end else if (load && (!EN || boundary)) begin
      active_data_reg  <= data;
      active_dots_reg  <= dots;
      active_blink_reg <= blink_mask;
      load_pending_reg <= 1'b0;
    end else if (load) begin
      pending_data_reg  <= data;
      pending_dots_reg  <= dots;
      pending_blink_reg <= blink_mask;
      load_pending_reg  <= 1'b1;
    end else if (boundary && load_pending_reg) begin
      active_data_reg  <= pending_data_reg;
      active_dots_reg  <= pending_dots_reg;
      active_blink_reg <= pending_blink_reg;
      load_pending_reg <= 1'b0;
    end
  end

  // Blink timing: count frames, flip phase every BLINK_DIV frames.
  always_ff @(posedge clk_200Hz) begin
    if (rst) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (boundary) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 8'd1;
      end
    end
  end

  assign sm_duan      = sm_duan_reg;
  assign sm_wei       = sm_wei_reg;
  assign frame_done   = frame_done_reg;
  assign load_pending = load_pending_reg;

endmodule

// File: tb/tb_display_scan_n.sv
// Directed bench for display_scan_n (4 digits, blink every 2 frames,
// active-low digit select, active-high segments).
module tb_display_scan_n;

  logic        clk_200Hz = 1'b0;
  logic        rst = 1'b0;
  logic        EN = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dots = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic [7:0]  sm_duan;
  logic [3:0]  sm_wei;
  logic        frame_done;
  logic        load_pending;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_n #(
    .N_DIGITS(4), .BLINK_DIV(2), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk_200Hz(clk_200Hz), .rst(rst), .EN(EN), .load(load), .data(data),
    .dots(dots), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .sm_duan(sm_duan), .sm_wei(sm_wei), .frame_done(frame_done),
    .load_pending(load_pending)
  );

  always #5 clk_200Hz = ~clk_200Hz;

  // Advance one clock; outputs are then stable for checking.
  task automatic step();
    @(posedge clk_200Hz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; EN = 1'b0; load = 1'b0; data = '0; dots = '0;
    blink_mask = '0; lz_blank = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; EN = 1'b1; load = 1'b1; data = 16'hFFFF; dots = 4'hF;
    step();
    n_cmp++; if (sm_wei !== 4'b1111) begin n_bad++; $display("FAIL reset_wei got %b want 1111", sm_wei); end
    n_cmp++; if (sm_duan !== 8'h00) begin n_bad++; $display("FAIL reset_duan got %h want 00", sm_duan); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got %b want 0", frame_done); end
    n_cmp++; if (load_pending !== 1'b0) begin n_bad++; $display("FAIL reset_lp got %b want 0", load_pending); end
    $display("test_reset done");
    rst = 1'b0; EN = 1'b0; load = 1'b0; data = '0; dots = '0;
  endtask

  task automatic test_scan_decode();
    logic [3:0] exp_wei [4];
    logic [7:0] exp_duan [4];
    exp_wei[0] = 4'b1110; exp_wei[1] = 4'b1101; exp_wei[2] = 4'b1011; exp_wei[3] = 4'b0111;
    exp_duan[0] = 8'h71; exp_duan[1] = 8'hF7; exp_duan[2] = 8'h5B; exp_duan[3] = 8'h06;
    do_reset();
    EN = 1'b0; load = 1'b1; data = 16'h12AF; dots = 4'b0010; lz_blank = 1'b0;
    step();
    load = 1'b0;
    n_cmp++; if (load_pending !== 1'b0) begin n_bad++; $display("FAIL scan_lp_idle got %b want 0", load_pending); end
    EN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++; if (sm_wei !== exp_wei[c % 4]) begin n_bad++; $display("FAIL scan_wei c=%0d got %b want %b", c, sm_wei, exp_wei[c % 4]); end
      n_cmp++; if (sm_duan !== exp_duan[c % 4]) begin n_bad++; $display("FAIL scan_duan c=%0d got %h want %h", c, sm_duan, exp_duan[c % 4]); end
      n_cmp++; if (frame_done !== (c == 3)) begin n_bad++; $display("FAIL scan_fd c=%0d got %b want %b", c, frame_done, (c == 3)); end
      $display("scan c=%0d wei=%b duan=%h fd=%b", c, sm_wei, sm_duan, frame_done);
    end
  endtask

  task automatic test_lz_blank();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a[0] = 8'h3F; exp_a[1] = 8'h6D; exp_a[2] = 8'h00; exp_a[3] = 8'h00;
    exp_b[0] = 8'h3F; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    do_reset();
    lz_blank = 1'b1; load = 1'b1; data = 16'h0050;
    step();
    load = 1'b0; EN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (sm_duan !== exp_a[c]) begin n_bad++; $display("FAIL lz0050 c=%0d got %h want %h", c, sm_duan, exp_a[c]); end
      $display("lz 0050 c=%0d duan=%h", c, sm_duan);
    end
    EN = 1'b0; load = 1'b1; data = 16'h0000;
    step();
    load = 1'b0;
    EN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (sm_duan !== exp_b[c]) begin n_bad++; $display("FAIL lz0000 c=%0d got %h want %h", c, sm_duan, exp_b[c]); end
      $display("lz 0000 c=%0d duan=%h", c, sm_duan);
    end
  endtask

  task automatic test_midframe_load();
    do_reset();
    load = 1'b1; data = 16'h1111;
    step();
    load = 1'b0; EN = 1'b1;
    step();                           // digit 0 shown, idx now 1
    load = 1'b1; data = 16'hFFFF;     // load during idx=1
    step();
    load = 1'b0;
    n_cmp++; if (load_pending !== 1'b1) begin n_bad++; $display("FAIL mid_lp_set got %b want 1", load_pending); end
    n_cmp++; if (sm_duan !== 8'h06) begin n_bad++; $display("FAIL mid_d1 got %h want 06", sm_duan); end
    step();
    n_cmp++; if (sm_duan !== 8'h06) begin n_bad++; $display("FAIL mid_d2 got %h want 06", sm_duan); end
    n_cmp++; if (load_pending !== 1'b1) begin n_bad++; $display("FAIL mid_lp_hold got %b want 1", load_pending); end
    step();                           // boundary cycle
    n_cmp++; if (sm_duan !== 8'h06) begin n_bad++; $display("FAIL mid_d3 got %h want 06", sm_duan); end
    n_cmp++; if (load_pending !== 1'b0) begin n_bad++; $display("FAIL mid_lp_clr got %b want 0", load_pending); end
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL mid_fd got %b want 1", frame_done); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (sm_duan !== 8'h71) begin n_bad++; $display("FAIL mid_new c=%0d got %h want 71", c, sm_duan); end
    end
    $display("test_midframe_load done");
  endtask

  task automatic test_boundary_load();
    do_reset();
    load = 1'b1; data = 16'h1111;
    step();
    load = 1'b0; EN = 1'b1;
    step(); step(); step();           // idx now 3
    load = 1'b1; data = 16'h2222;
    step();
    load = 1'b0;
    n_cmp++; if (load_pending !== 1'b0) begin n_bad++; $display("FAIL bnd_lp got %b want 0", load_pending); end
    n_cmp++; if (sm_duan !== 8'h06) begin n_bad++; $display("FAIL bnd_d3 got %h want 06", sm_duan); end
    step();
    n_cmp++; if (sm_duan !== 8'h5B) begin n_bad++; $display("FAIL bnd_next got %h want 5B", sm_duan); end
    $display("test_boundary_load done");
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    do_reset();
    load = 1'b1; data = 16'h1111; blink_mask = 4'b0001;
    step();
    load = 1'b0; EN = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp = (c == 0 && ((f / 2) % 2 == 1)) ? 8'h00 : 8'h06;
        n_cmp++; if (sm_duan !== exp) begin n_bad++; $display("FAIL blink f=%0d c=%0d got %h want %h", f, c, sm_duan, exp); end
        n_cmp++; if (frame_done !== (c == 3)) begin n_bad++; $display("FAIL blink_fd f=%0d c=%0d got %b want %b", f, c, frame_done, (c == 3)); end
      end
      $display("blink frame %0d checked", f);
    end
  endtask

  task automatic test_enable_gap_and_reset();
    do_reset();
    load = 1'b1; data = 16'h1234;
    step();
    load = 1'b0; EN = 1'b1;
    step(); step();                   // idx now 2
    EN = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++; if (sm_wei !== 4'b1111) begin n_bad++; $display("FAIL gap_wei c=%0d got %b want 1111", c, sm_wei); end
      n_cmp++; if (sm_duan !== 8'h00) begin n_bad++; $display("FAIL gap_duan c=%0d got %h want 00", c, sm_duan); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL gap_fd c=%0d got %b want 0", c, frame_done); end
    end
    EN = 1'b1;
    step();
    n_cmp++; if (sm_wei !== 4'b1011) begin n_bad++; $display("FAIL resume_wei got %b want 1011", sm_wei); end
    n_cmp++; if (sm_duan !== 8'h5B) begin n_bad++; $display("FAIL resume_duan got %h want 5B", sm_duan); end
    step(); step();                   // boundary, then idx0; idx now 1
    load = 1'b1; data = 16'hFFFF;
    step();
    n_cmp++; if (load_pending !== 1'b1) begin n_bad++; $display("FAIL rst_pre_lp got %b want 1", load_pending); end
    rst = 1'b1;
    step();
    n_cmp++; if (sm_wei !== 4'b1111) begin n_bad++; $display("FAIL rst_wei got %b want 1111", sm_wei); end
    n_cmp++; if (sm_duan !== 8'h00) begin n_bad++; $display("FAIL rst_duan got %h want 00", sm_duan); end
    n_cmp++; if (load_pending !== 1'b0) begin n_bad++; $display("FAIL rst_lp got %b want 0", load_pending); end
    rst = 1'b0; load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++; if (sm_duan !== 8'h3F) begin n_bad++; $display("FAIL post_rst c=%0d got %h want 3F", c, sm_duan); end
      if (c == 0) begin
        n_cmp++; if (sm_wei !== 4'b1110) begin n_bad++; $display("FAIL post_rst_wei got %b want 1110", sm_wei); end
      end
    end
    $display("test_enable_gap_and_reset done");
  endtask

  initial begin
    test_reset();
    test_scan_decode();
    test_lz_blank();
    test_midframe_load();
    test_boundary_load();
    test_blink();
    test_enable_gap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_n.md
DISPLAY_SCAN_N -- requirements
Module: display_scan_n

Interface
REQ-001 Parameter N_DIGITS, default 8, digit count; legal range 2..8.
REQ-002 Parameter BLINK_DIV, default 50, frames per blink half-period; legal range 1..255.
REQ-003 Parameter AN_ACTIVE_LOW, default 1; 1 = sm_wei bit low selects digit.
REQ-004 Parameter SEG_ACTIVE_LOW, default 0; 1 = sm_duan bit low lights segment.
REQ-005 Single clock; reset is synchronous and active-high.
REQ-006 clk_200Hz  in  1  scan clock, rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 EN  in  1  display enable.
REQ-009 load  in  1  single-cycle strobe capturing data, dots, blink_mask.
REQ-010 data  in  4*N_DIGITS  hex nibbles; data[4k+3:4k] = digit k; digit 0 rightmost.
REQ-011 dots  in  N_DIGITS  decimal point per digit.
REQ-012 blink_mask  in  N_DIGITS  1 = digit blinks.
REQ-013 lz_blank  in  1  leading-zero blanking enable; sampled live each cycle.
REQ-014 sm_duan  out  8  segments, bit0..6 = a..g, bit7 = dp; registered.
REQ-015 sm_wei  out  N_DIGITS  digit select, bit k = digit k; one-hot or none active; registered.
REQ-016 frame_done  out  1  one-cycle pulse per completed scan frame.
REQ-017 load_pending  out  1  captured data awaiting frame boundary.

Function
REQ-018 Scan index idx counts 0..N_DIGITS-1, +1 per cycle while EN=1, wraps N_DIGITS-1 -> 0; held while EN=0.
REQ-019 Latency 1 cycle: cycle with idx=k and EN=1 -> next cycle sm_wei selects digit k only, sm_duan shows digit k.
REQ-020 Decode (active-high, bits g..a) 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; dp = dots[k]; whole byte inverted when SEG_ACTIVE_LOW=1.
REQ-021 Double buffer: load with EN=1 captures inputs into pending registers, sets load_pending; load while pending overwrites pending.
REQ-022 Frame boundary = cycle with EN=1 and idx=N_DIGITS-1; pending copies to active registers, load_pending clears, visible from next frame.
REQ-023 load on a frame-boundary cycle: inputs written straight to active, load_pending stays/becomes 0.
REQ-024 load with EN=0: inputs written straight to active, load_pending cleared.
REQ-025 frame_done asserts the cycle after each frame-boundary cycle, exactly one cycle.
REQ-026 Leading-zero blanking (lz_blank=1): digit k>=1 blanked (a..g off) if active nibbles k..N_DIGITS-1 all zero; digit 0 never blanked; dp still follows dots[k].
REQ-027 Blink counter counts frame boundaries 0..BLINK_DIV-1, wraps and toggles blink_phase at wrap; held while EN=0.
REQ-028 blink_phase=1 and blink_mask_active[k]=1: digit k fully dark (all segments and dp off), sm_wei still selects it.
REQ-029 EN=0: next cycle sm_wei all inactive and sm_duan all off (polarity-adjusted); EN 0->1 resumes scan at held idx.

Reset
REQ-030 rst=1 at a clock edge: idx=0, active/pending registers 0, load_pending=0, blink counter 0, blink_phase 0, frame_done 0, sm_wei all inactive, sm_duan all off; overrides EN and load.
REQ-031 rst mid-frame discards pending data; first digit shown after release is digit 0 (showing "0" if lz_blank=0).

Verification (N_DIGITS=4, BLINK_DIV=2, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0)
REQ-032 rst, EN=1, load data=16'h12AF dots=4'b0010 lz_blank=0, with EN=0 -> after EN=1, sm_wei cycles 1110,1101,1011,0111 with sm_duan 71,77(+80 at digit1 =F7),5B,06.
REQ-033 lz_blank=1, data=16'h0050 loaded -> digit3 and digit2 sm_duan=00, digit1=6D, digit0=3F; data=16'h0000 -> only digit0 shows 3F.
REQ-034 Mid-frame load (idx=1) of 16'hFFFF over 16'h1111 -> load_pending=1, remaining digits show 06, FFFF (71) appears from next frame, load_pending drops after boundary cycle.
REQ-035 blink_mask=4'b0001 -> digit0 sm_duan=00 for 2 frames, lit for 2 frames, repeating; other digits unaffected; frame_done once per 4 cycles.
REQ-036 EN dropped at idx=2 for 5 cycles -> sm_wei=1111, sm_duan=00, no frame_done; on re-enable digit2 displayed first; rst asserted mid-scan -> all outputs at REQ-030 values next cycle.
